// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and clear-FSM encodings for data_memory_be
package mem_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
endpackage

// File: rtl/byte_lane_align.sv
// byte_lane_align: lane mask, store replication, load extraction/extension and alignment check
// Ports: addr_lo byte offset, size access size, is_unsigned zero-extend select, rd_word raw RAM word,
//        wr_data store data; lane_mask byte enables, st_word lane-replicated store data,
//        ld_word extended load result, misalign natural-alignment violation
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [3:0]  lane_mask,
  output logic [31:0] st_word,
  output logic [31:0] ld_word,
  output logic        misalign
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    misalign  = (size == SIZE_BYTE) ? 1'b0 : (size == SIZE_HALF) ? addr_lo[0] : (addr_lo != 2'b00);
    lane_mask = (size == SIZE_BYTE) ? 4'b0001 << addr_lo :
                (size == SIZE_HALF) ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    st_word   = (size == SIZE_BYTE) ? {4{wr_data[7:0]}} : (size == SIZE_HALF) ? {2{wr_data[15:0]}} : wr_data;
    ld_byte   = rd_word[8*addr_lo +: 8];
    ld_half   = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    ld_word   = (size == SIZE_BYTE) ? {{24{~is_unsigned & ld_byte[7]}}, ld_byte} :
                (size == SIZE_HALF) ? {{16{~is_unsigned & ld_half[15]}}, ld_half} : rd_word;
  end
endmodule

// File: rtl/data_memory_be.sv
// data_memory_be: byte-enabled data memory with combinational reads and post-reset hardware clear
// Ports: clk, reset (async active-low), MemRead/MemWrite requests, Address byte address, Size access size,
//        Unsigned zero-extend select, Write_data store data; Read_data extended load, Busy clear in progress,
//        Misaligned alignment violation on an active access
module data_memory_be
  import mem_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_BITS   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [31:0]           Write_data,
  output logic [31:0]           Read_data,
  output logic                  Busy,
  output logic                  Misaligned
);
  logic [31:0]         mem [DEPTH];
  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] clr_ptr_q, clr_ptr_d;
  logic [IDX_BITS-1:0] idx;
  logic [3:0]          lane_mask;
  logic [31:0]         st_word, ld_word;
  logic                mis, we;
  logic                unused_addr;
  assign idx         = Address[IDX_BITS+1:2];
  assign unused_addr = ^Address;
  byte_lane_align u_align (
    .addr_lo    (Address[1:0]),
    .size       (Size),
    .is_unsigned(Unsigned),
    .rd_word    (mem[idx]),
    .wr_data    (Write_data),
    .lane_mask  (lane_mask),
    .st_word    (st_word),
    .ld_word    (ld_word),
    .misalign   (mis)
  );
  always_comb begin
    Busy       = (state_q == ST_CLEAR);
    clr_ptr_d  = Busy ? clr_ptr_q + 1'b1 : clr_ptr_q;
    // DEPTH is a power of two, so all-ones marks the last word
    state_d    = (Busy && &clr_ptr_q) ? ST_READY : state_q;
    Misaligned = !Busy && (MemRead || MemWrite) && mis;
    we         = !Busy && MemWrite && !mis;
    Read_data  = (!Busy && MemRead && !mis) ? ld_word : 32'h0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end
  // RAM has no reset; the clear sequencer zeroes it after reset releases
  always_ff @(posedge clk) begin
    if (Busy) mem[clr_ptr_q] <= 32'h0;
    else if (we)
      for (int i = 0; i < 4; i++)
        if (lane_mask[i]) mem[idx][8*i +: 8] <= st_word[8*i +: 8];
  end
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: directed self-checking bench for data_memory_be
module tb_data_memory_be;
  import mem_pkg::*;
  localparam int DEPTH = 64;
  logic        clk = 0, reset = 0, MemRead = 0, MemWrite = 0, Unsigned = 0;
  logic [31:0] Address = 0, Write_data = 0, Read_data, d;
  logic [1:0]  Size = SIZE_WORD;
  logic        Busy, Misaligned;
  int          total = 0, bad = 0, n;

  data_memory_be #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Size(Size), .Unsigned(Unsigned), .Write_data(Write_data), .Read_data(Read_data),
    .Busy(Busy), .Misaligned(Misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] s, input logic u, output logic [31:0] r);
    Address = a; Size = s; Unsigned = u; MemRead = 1; MemWrite = 0;
    #1 r = Read_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] v);
    @(negedge clk);
    Address = a; Size = s; Write_data = v; MemRead = 0; MemWrite = 1;
    @(posedge clk);
    #1 MemWrite = 0;
  endtask

  task automatic count_busy(input string tag);
    n = 0;
    while (Busy === 1'b1 && n < 4*DEPTH) begin
      @(posedge clk);
      #1 n++;
    end
    chk(tag, n, DEPTH);
  endtask

  initial begin
    MemRead = 1; Address = 32'h41; Size = SIZE_WORD;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", Busy, 1);
    chk("rst_rdata", Read_data, 0);
    chk("rst_mis", Misaligned, 0);
    @(negedge clk) reset = 1; MemRead = 0;
    #1 chk("busy_after_release", Busy, 1);
    count_busy("busy_edges");
    chk("busy_low", Busy, 0);
    rd(32'h0, SIZE_WORD, 0, d); chk("clr_0", d, 0);
    rd(32'h4, SIZE_WORD, 0, d); chk("clr_4", d, 0);
    rd(4*(DEPTH-1), SIZE_WORD, 0, d); chk("clr_last", d, 0);

    wr(32'h10, SIZE_WORD, 32'h12345678);
    wr(32'h13, SIZE_BYTE, 32'h000000AB);
    rd(32'h10, SIZE_WORD, 0, d); chk("byte_merge", d, 32'hAB345678);
    rd(32'h13, SIZE_BYTE, 0, d); chk("lb_signed", d, 32'hFFFFFFAB);
    rd(32'h13, SIZE_BYTE, 1, d); chk("lb_unsigned", d, 32'h000000AB);
    rd(32'h11, SIZE_BYTE, 0, d); chk("lb_lane1", d, 32'h00000056);
    MemRead = 0; #1 chk("rd_disabled", Read_data, 0);

    wr(32'h22, SIZE_HALF, 32'hCAFE8001);
    rd(32'h22, SIZE_HALF, 0, d); chk("lh_signed", d, 32'hFFFF8001);
    rd(32'h22, SIZE_HALF, 1, d); chk("lh_unsigned", d, 32'h00008001);
    rd(32'h20, SIZE_WORD, 0, d); chk("half_word", d, 32'h80010000);

    wr(32'h40, SIZE_WORD, 32'h11223344);
    @(negedge clk);
    Address = 32'h41; Size = SIZE_WORD; Write_data = 32'hDEADBEEF; MemRead = 0; MemWrite = 1;
    #1 chk("st_mis_flag", Misaligned, 1);
    @(posedge clk);
    #1 MemWrite = 0;
    rd(32'h40, SIZE_WORD, 0, d); chk("st_mis_kept", d, 32'h11223344);
    rd(32'h41, SIZE_HALF, 0, d); chk("lh_mis_data", d, 0);
    chk("lh_mis_flag", Misaligned, 1);
    rd(32'h43, SIZE_BYTE, 0, d); chk("lb_odd_ok", Misaligned, 0);

    wr(32'h30, SIZE_WORD, 32'h1);
    @(negedge clk);
    Address = 32'h30; Size = SIZE_WORD; Write_data = 32'h2; MemRead = 1; MemWrite = 1;
    #1 chk("same_cycle_old", Read_data, 32'h1);
    @(posedge clk);
    #1 chk("same_cycle_new", Read_data, 32'h2);
    MemWrite = 0;
    rd(4*DEPTH + 32'h30, SIZE_WORD, 0, d); chk("alias", d, 32'h2);
    wr(4*DEPTH + 32'h34, SIZE_WORD, 32'h77);
    rd(32'h34, SIZE_WORD, 0, d); chk("alias_wr", d, 32'h77);

    wr(32'h8, SIZE_WORD, 32'h55);
    rd(32'h8, SIZE_WORD, 0, d); chk("pre_reset_store", d, 32'h55);
    MemRead = 0;
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
    repeat (DEPTH/2) @(posedge clk);
    @(negedge clk) reset = 0;
    #1 chk("midclear_busy", Busy, 1);
    @(negedge clk) reset = 1;
    count_busy("reclear_edges");
    rd(32'h8, SIZE_WORD, 0, d); chk("reclear_8", d, 0);
    rd(32'h10, SIZE_WORD, 0, d); chk("reclear_10", d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
